assoc_cache_controller: RTL and testbench

ASSOC_CACHE_CONTROLLER -- requirements
Module: assoc_cache_controller

---
 rtl/cache_pkg.sv | 23 ++
 rtl/cache_way_array.sv | 74 +++++++
 rtl/assoc_cache_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_assoc_cache_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the two-way set-associative cache controller:
// FSM state encoding and default geometry.
package cache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_WORDS_PER_LINE = 2;
    localparam int DEF_SETS           = 64;
    localparam int DEF_BASE_ADDR      = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Tag bits left over once byte, word and set bits are removed.
    function automatic int tag_width(input int addr_w, input int words, input int sets);
        return addr_w - $clog2(words) - 2 - $clog2(sets);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// Two-way tag/valid/line storage with one LRU bit per set. Reads are
// combinational on set_idx; fills, LRU updates and invalidates land on the clock edge.
module cache_way_array #(
    parameter int SETS   = 64,
    parameter int SET_W  = 6,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SET_W-1:0]  set_idx,
    input  logic              line_we,
    input  logic              line_way,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic [LINE_W-1:0] line_data,
    input  logic              lru_we,
    input  logic              lru_val,
    input  logic              inv_we,
    output logic [1:0]        valid,
    output logic [TAG_W-1:0]  tag0,
    output logic [TAG_W-1:0]  tag1,
    output logic [LINE_W-1:0] line0,
    output logic [LINE_W-1:0] line1,
    output logic              lru
);

    logic [SETS-1:0]   valid0_q;
    logic [SETS-1:0]   valid1_q;
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag0_mem  [SETS];
    logic [TAG_W-1:0]  tag1_mem  [SETS];
    logic [LINE_W-1:0] line0_mem [SETS];
    logic [LINE_W-1:0] line1_mem [SETS];

    assign valid = {valid1_q[set_idx], valid0_q[set_idx]};
    assign tag0  = tag0_mem[set_idx];
    assign tag1  = tag1_mem[set_idx];
    assign line0 = line0_mem[set_idx];
    assign line1 = line1_mem[set_idx];
    assign lru   = lru_q[set_idx];

    // Only the control bits are reset; tag and data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (inv_we) begin
                valid0_q[set_idx] <= 1'b0;
                valid1_q[set_idx] <= 1'b0;
                lru_q[set_idx]    <= 1'b0;
            end
            if (line_we) begin
                if (line_way) valid1_q[set_idx] <= 1'b1;
                else          valid0_q[set_idx] <= 1'b1;
            end
            if (lru_we) lru_q[set_idx] <= lru_val;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            if (line_way) begin
                tag1_mem[set_idx]  <= line_tag;
                line1_mem[set_idx] <= line_data;
            end else begin
                tag0_mem[set_idx]  <= line_tag;
                line0_mem[set_idx] <= line_data;
            end
        end
    end

endmodule

// File: rtl/assoc_cache_controller.sv
// Two-way set-associative, write-through / no-write-allocate cache controller
// sitting between a CPU load/store port and a line-oriented SRAM controller.
module assoc_cache_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
    parameter int SETS           = DEF_SETS,
    parameter int BASE_ADDR      = DEF_BASE_ADDR
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                address,
    input  logic [DATA_W-1:0]                wdata,
    input  logic                             mem_r_en,
    input  logic                             mem_w_en,
    input  logic                             flush,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] sram_rdata,
    input  logic                             sram_ready,
    output logic [DATA_W-1:0]                rdata,
    output logic                             ready,
    output logic [ADDR_W-1:0]                sram_address,
    output logic [DATA_W-1:0]                sram_wdata,
    output logic                             sram_write,
    output logic                             sram_read
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int WORD_W = (OFF_W > 0) ? OFF_W : 1;
    localparam int SET_W  = $clog2(SETS);
    localparam int LOW_W  = OFF_W + 2;
    localparam int TAG_W  = tag_width(ADDR_W, WORDS_PER_LINE, SETS);
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;

    // CPU handshake: a load or store is held on mem_r_en/mem_w_en until the
    // cycle ready=1 is seen; that cycle carries rdata and the request retires
    // at the following edge. SRAM side: sram_read/sram_write stay high until
    // sram_ready, and the transfer completes in the sram_ready cycle.

    state_t            state;
    logic [SET_W-1:0]  flush_cnt;

    logic [ADDR_W-1:0] off;
    logic [WORD_W-1:0] word;
    logic [SET_W-1:0]  set_sel;
    logic [TAG_W-1:0]  tag;
    logic              unused_low;

    logic [SET_W-1:0]  set_idx;
    logic              line_we;
    logic              line_way;
    logic [LINE_W-1:0] line_data;
    logic              lru_we;
    logic              lru_val;
    logic              inv_we;

    logic [1:0]        way_valid;
    logic [TAG_W-1:0]  tag0;
    logic [TAG_W-1:0]  tag1;
    logic [LINE_W-1:0] line0;
    logic [LINE_W-1:0] line1;
    logic              lru;

    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              victim;
    logic [LINE_W-1:0] hit_line;
    logic [LINE_W-1:0] merged_line;
    logic [DATA_W-1:0] hit_word;
    logic [DATA_W-1:0] fill_word;

    assign off        = address - ADDR_W'(BASE_ADDR);
    assign set_sel    = off[LOW_W +: SET_W];
    assign tag        = off[ADDR_W-1 -: TAG_W];
    assign unused_low = ^off[1:0];

    generate
        if (OFF_W > 0) begin : g_word
            assign word = off[2 +: OFF_W];
        end else begin : g_single
            assign word = '0;
        end
    endgenerate

    assign hit0     = way_valid[0] && (tag0 == tag);
    assign hit1     = way_valid[1] && (tag1 == tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_line = hit_way ? line1 : line0;
    assign hit_word = hit_line[int'(word)*DATA_W +: DATA_W];
    assign fill_word = sram_rdata[int'(word)*DATA_W +: DATA_W];

    // Prefer an empty way (way 0 first) before evicting the LRU way.
    assign victim = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru);

    always_comb begin
        merged_line = hit_line;
        merged_line[int'(word)*DATA_W +: DATA_W] = wdata;
    end

    cache_way_array #(
        .SETS   (SETS),
        .SET_W  (SET_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_ways (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (set_idx),
        .line_we   (line_we),
        .line_way  (line_way),
        .line_tag  (tag),
        .line_data (line_data),
        .lru_we    (lru_we),
        .lru_val   (lru_val),
        .inv_we    (inv_we),
        .valid     (way_valid),
        .tag0      (tag0),
        .tag1      (tag1),
        .line0     (line0),
        .line1     (line1),
        .lru       (lru)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_cnt <= '0;
                    if (flush)                 state <= FLUSH;
                    else if (mem_w_en)         state <= WRITE;
                    else if (mem_r_en && !hit) state <= READ;
                end
                READ:  if (sram_ready) state <= IDLE;
                WRITE: if (sram_ready) state <= IDLE;
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == SET_W'(SETS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready        = 1'b0;
        rdata        = '0;
        sram_address = '0;
        sram_wdata   = '0;
        sram_write   = 1'b0;
        sram_read    = 1'b0;
        set_idx      = set_sel;
        line_we      = 1'b0;
        line_way     = 1'b0;
        line_data    = sram_rdata;
        lru_we       = 1'b0;
        lru_val      = 1'b0;
        inv_we       = 1'b0;

        case (state)
            IDLE: begin
                if (!flush && !mem_w_en) begin
                    if (!mem_r_en) begin
                        ready = 1'b1;
                    end else if (hit) begin
                        ready   = 1'b1;
                        rdata   = hit_word;
                        lru_we  = 1'b1;
                        lru_val = !hit_way;
                    end
                end
            end
            READ: begin
                sram_read    = 1'b1;
                sram_address = {address[ADDR_W-1:LOW_W], LOW_W'(0)};
                if (sram_ready) begin
                    ready    = 1'b1;
                    rdata    = fill_word;
                    line_we  = 1'b1;
                    line_way = victim;
                    lru_we   = 1'b1;
                    lru_val  = !victim;
                end
            end
            WRITE: begin
                sram_write   = 1'b1;
                sram_address = address;
                sram_wdata   = wdata;
                if (sram_ready) begin
                    ready = 1'b1;
                    if (hit) begin
                        line_we   = 1'b1;
                        line_way  = hit_way;
                        line_data = merged_line;
                        lru_we    = 1'b1;
                        lru_val   = !hit_way;
                    end
                end
            end
            FLUSH: begin
                set_idx = flush_cnt;
                inv_we  = 1'b1;
            end
            default: ;
        endcase

        // While reset is held the port looks like an idle, empty cache.
        if (!rst) begin
            ready        = 1'b1;
            rdata        = '0;
            sram_address = '0;
            sram_wdata   = '0;
            sram_write   = 1'b0;
            sram_read    = 1'b0;
            line_we      = 1'b0;
            lru_we       = 1'b0;
            inv_we       = 1'b0;
        end
    end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Directed bench for assoc_cache_controller at default parameters: cold miss,
// hit, LRU eviction, write-through store, flush and mid-transaction reset.
module tb_assoc_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        flush;
    logic [63:0] sram_rdata;
    logic        sram_ready;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_write;
    logic        sram_read;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assoc_cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .flush        (flush),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_write   (sram_write),
        .sram_read    (sram_read)
    );

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        address = '0; wdata = '0; mem_r_en = 0; mem_w_en = 0;
        flush = 0; sram_rdata = '0; sram_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    // SRAM answers after `delay` cycles of sram_read have been seen.
    task automatic cpu_read(input logic [31:0] addr, input logic [63:0] line, input int delay,
                            output logic [31:0] data, output int waits, output logic saw_rd,
                            output logic [31:0] saw_addr, output logic done);
        int rd_cycles;
        rd_cycles = 0; waits = 0; saw_rd = 0; saw_addr = '0; data = '0; done = 0;
        @(negedge clk);
        address = addr; mem_r_en = 1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (sram_read) begin
                saw_rd = 1; saw_addr = sram_address; rd_cycles++;
                if (rd_cycles > delay) begin
                    sram_rdata = line; sram_ready = 1; #1;
                end
            end
            if (ready) begin
                data = rdata; done = 1;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        mem_r_en = 0; sram_ready = 0; sram_rdata = '0; address = '0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data, input int delay,
                             input logic also_read, output int waits, output logic saw_wr,
                             output logic saw_rd, output logic [31:0] saw_addr,
                             output logic [31:0] saw_wdata, output logic done);
        int wr_cycles;
        wr_cycles = 0; waits = 0; saw_wr = 0; saw_rd = 0; saw_addr = '0; saw_wdata = '0; done = 0;
        @(negedge clk);
        address = addr; wdata = data; mem_w_en = 1; mem_r_en = also_read;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (sram_read) saw_rd = 1;
            if (sram_write) begin
                saw_wr = 1; saw_addr = sram_address; saw_wdata = sram_wdata; wr_cycles++;
                if (wr_cycles > delay) begin
                    sram_ready = 1; #1;
                end
            end
            if (ready) done = 1;
            else begin
                waits++;
                @(negedge clk);
            end
        end
        @(posedge clk); #1;
        mem_w_en = 0; mem_r_en = 0; sram_ready = 0; address = '0; wdata = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 0;
        mem_r_en = 1; address = 32'h408;
        @(posedge clk); #1;
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else pass_cnt++;
        total_cnt++; if (sram_read !== 1'b0 || sram_write !== 1'b0)
            $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", sram_read, sram_write); else pass_cnt++;
        total_cnt++; if (sram_address !== 32'h0 || sram_wdata !== 32'h0)
            $display("FAIL reset_sram_bus: got addr=%h wdata=%h expected 0 0", sram_address, sram_wdata); else pass_cnt++;
        @(negedge clk);
        mem_r_en = 0; address = '0; rst = 1;
        #1;
        total_cnt++; if (ready !== 1'b1 || sram_read !== 1'b0)
            $display("FAIL post_reset_idle: got ready=%b rd=%b expected 1 0", ready, sram_read); else pass_cnt++;
    endtask

    task automatic test_cold_read_and_hit();
        logic [31:0] d, a; int w; logic s, ok;
        do_reset();
        cpu_read(32'h408, 64'h22222222_11111111, 3, d, w, s, a, ok);
        total_cnt++; if (ok !== 1'b1) $display("FAIL cold_read_timeout: got done=%b expected 1", ok); else pass_cnt++;
        total_cnt++; if (s !== 1'b1 || a !== 32'h408)
            $display("FAIL cold_read_sram: got rd=%b addr=%h expected 1 00000408", s, a); else pass_cnt++;
        total_cnt++; if (d !== 32'h11111111) $display("FAIL cold_read_data: got %h expected 11111111", d); else pass_cnt++;
        total_cnt++; if (w !== 4) $display("FAIL cold_read_latency: got %0d expected 4", w); else pass_cnt++;
        cpu_read(32'h40C, 64'hFFFFFFFF_FFFFFFFF, 0, d, w, s, a, ok);
        total_cnt++; if (d !== 32'h22222222) $display("FAIL hit_data: got %h expected 22222222", d); else pass_cnt++;
        total_cnt++; if (w !== 0 || s !== 1'b0)
            $display("FAIL hit_zero_wait: got waits=%0d rd=%b expected 0 0", w, s); else pass_cnt++;
    endtask

    task automatic test_lru_eviction();
        logic [31:0] d, a; int w; logic s, ok;
        do_reset();
        cpu_read(32'h408, 64'hA0000001_A0000000, 0, d, w, s, a, ok);
        cpu_read(32'h60C, 64'hB0000001_B0000000, 1, d, w, s, a, ok);
        total_cnt++; if (a !== 32'h608 || d !== 32'hB0000001)
            $display("FAIL miss_aligned: got addr=%h data=%h expected 00000608 b0000001", a, d); else pass_cnt++;
        cpu_read(32'h408, 64'h0, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b0 || d !== 32'hA0000000)
            $display("FAIL lru_touch_hit: got rd=%b data=%h expected 0 a0000000", s, d); else pass_cnt++;
        cpu_read(32'h808, 64'hC0000001_C0000000, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b1 || d !== 32'hC0000000)
            $display("FAIL evict_fill: got rd=%b data=%h expected 1 c0000000", s, d); else pass_cnt++;
        cpu_read(32'h408, 64'h0, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b0 || d !== 32'hA0000000)
            $display("FAIL mru_kept: got rd=%b data=%h expected 0 a0000000", s, d); else pass_cnt++;
        cpu_read(32'h60C, 64'hD0000001_D0000000, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b1 || d !== 32'hD0000001)
            $display("FAIL victim_gone: got rd=%b data=%h expected 1 d0000001", s, d); else pass_cnt++;
    endtask

    task automatic test_store();
        logic [31:0] d, a, wd; int w; logic s, sw, ok;
        do_reset();
        cpu_read(32'h408, 64'h22222222_11111111, 0, d, w, s, a, ok);
        cpu_write(32'h40C, 32'hDEADBEEF, 2, 1'b0, w, sw, s, a, wd, ok);
        total_cnt++; if (sw !== 1'b1 || a !== 32'h40C || wd !== 32'hDEADBEEF)
            $display("FAIL store_sram: got wr=%b addr=%h wdata=%h expected 1 0000040c deadbeef", sw, a, wd); else pass_cnt++;
        total_cnt++; if (w !== 3 || ok !== 1'b1)
            $display("FAIL store_latency: got waits=%0d done=%b expected 3 1", w, ok); else pass_cnt++;
        cpu_read(32'h40C, 64'h0, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b0 || d !== 32'hDEADBEEF)
            $display("FAIL store_hit_update: got rd=%b data=%h expected 0 deadbeef", s, d); else pass_cnt++;
        cpu_read(32'h408, 64'h0, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b0 || d !== 32'h11111111)
            $display("FAIL store_other_word: got rd=%b data=%h expected 0 11111111", s, d); else pass_cnt++;
        cpu_write(32'h1000, 32'h12345678, 0, 1'b0, w, sw, s, a, wd, ok);
        cpu_read(32'h1000, 64'h00000002_00000001, 1, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b1 || d !== 32'h00000001 || w !== 2)
            $display("FAIL no_write_allocate: got rd=%b data=%h waits=%0d expected 1 00000001 2", s, d, w); else pass_cnt++;
        cpu_write(32'h408, 32'hCAFEF00D, 0, 1'b1, w, sw, s, a, wd, ok);
        total_cnt++; if (sw !== 1'b1 || s !== 1'b0 || a !== 32'h408)
            $display("FAIL both_en_is_store: got wr=%b rd=%b addr=%h expected 1 0 00000408", sw, s, a); else pass_cnt++;
        cpu_read(32'h408, 64'h0, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b0 || d !== 32'hCAFEF00D)
            $display("FAIL both_en_update: got rd=%b data=%h expected 0 cafef00d", s, d); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] d, a; int w; logic s, ok; int bad;
        do_reset();
        cpu_read(32'h408, 64'h22222222_11111111, 0, d, w, s, a, ok);
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ready !== 1'b0) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL flush_busy: got %0d ready cycles expected 0", bad); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (ready !== 1'b1) $display("FAIL flush_done: got ready=%b expected 1", ready); else pass_cnt++;
        cpu_read(32'h408, 64'h44444444_33333333, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b1 || d !== 32'h33333333)
            $display("FAIL flush_invalidated: got rd=%b data=%h expected 1 33333333", s, d); else pass_cnt++;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, a; int w; logic s, ok, got_rd;
        do_reset();
        cpu_read(32'h60C, 64'h66666666_55555555, 0, d, w, s, a, ok);
        @(negedge clk);
        address = 32'h408; mem_r_en = 1;
        got_rd = 0;
        for (int i = 0; i < 10 && !got_rd; i++) begin
            @(negedge clk); #1;
            if (sram_read) got_rd = 1;
        end
        total_cnt++; if (got_rd !== 1'b1) $display("FAIL mid_read_enter: got rd=%b expected 1", got_rd); else pass_cnt++;
        rst = 0;
        @(posedge clk); #1;
        rst = 1; mem_r_en = 0; address = '0;
        #1;
        total_cnt++; if (sram_read !== 1'b0 || ready !== 1'b1)
            $display("FAIL mid_read_abandon: got rd=%b ready=%b expected 0 1", sram_read, ready); else pass_cnt++;
        cpu_read(32'h608, 64'h88888888_77777777, 0, d, w, s, a, ok);
        total_cnt++; if (s !== 1'b1 || d !== 32'h77777777)
            $display("FAIL reset_invalidates: got rd=%b data=%h expected 1 77777777", s, d); else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_cold_read_and_hit();
        test_lru_eviction();
        test_store();
        test_flush();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
